// File: rtl/video_source_mux_pkg.sv
// Shared types and constants for the video source selector and its stale watchdog.
package video_pkg;

    localparam int PKG_DATA_W = 8;
    localparam int MISS_CNT_W = 4;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] r;
        logic [PKG_DATA_W-1:0] g;
        logic [PKG_DATA_W-1:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        FALLBACK = 1'b1
    } mux_state_e;

    function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
        return (v == {MISS_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/video_source_mux_if.sv
// Pixel-source, timing and output bundle of video_source_mux.
interface video_source_mux_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]          src_valid;
    logic [NUM_SRC*3*DATA_W-1:0] src_rgb;
    logic [SEL_W-1:0]            sel_req;
    logic                        fallback_en;
    logic                        vde;
    logic                        hsync;
    logic                        vsync;
    logic                        start_of_frame;
    logic [DATA_W-1:0]           out_red;
    logic [DATA_W-1:0]           out_green;
    logic [DATA_W-1:0]           out_blue;
    logic                        out_vde;
    logic                        out_hsync;
    logic                        out_vsync;
    logic [SEL_W-1:0]            act_sel;
    logic                        stale;
    logic                        switch_pulse;

    modport master (
        output src_valid, src_rgb, sel_req, fallback_en, vde, hsync, vsync, start_of_frame,
        input  out_red, out_green, out_blue, out_vde, out_hsync, out_vsync, act_sel, stale, switch_pulse
    );

    modport slave (
        input  src_valid, src_rgb, sel_req, fallback_en, vde, hsync, vsync, start_of_frame,
        output out_red, out_green, out_blue, out_vde, out_hsync, out_vsync, act_sel, stale, switch_pulse
    );
endinterface

// File: rtl/video_source_mux_watchdog.sv
// Per-frame miss counter and RUN/FALLBACK decision for the currently selected source.
module stale_watchdog
    import video_pkg::*;
#(
    parameter int STALE_FRAMES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic seen_sel,
    input  logic start_of_frame,
    input  logic sel_changed,
    input  logic fallback_en,
    input  logic is_src0,
    output logic in_fallback,
    output logic fallback_next
);
    localparam logic [MISS_CNT_W-1:0] STALE_L = STALE_FRAMES[MISS_CNT_W-1:0];

    mux_state_e            state_q, state_d;
    logic [MISS_CNT_W-1:0] miss_q, miss_d;

    // State and miss counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            miss_q  <= {MISS_CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    // Frame-boundary evaluation; the counter restarts whenever the source changes
    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        if (start_of_frame) begin
            if (sel_changed || seen_sel || is_src0) begin
                miss_d = {MISS_CNT_W{1'b0}};
            end else begin
                miss_d = sat_inc(miss_q);
            end
            case (state_q)
                RUN: begin
                    if (fallback_en && !is_src0 && (miss_d >= STALE_L)) begin
                        state_d = FALLBACK;
                    end else begin
                        state_d = RUN;
                    end
                end
                FALLBACK: begin
                    if (seen_sel || !fallback_en || is_src0) begin
                        state_d = RUN;
                    end else begin
                        state_d = FALLBACK;
                    end
                end
                default: state_d = RUN;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign in_fallback   = (state_q == FALLBACK);
    assign fallback_next = (state_d == FALLBACK);

endmodule

// File: rtl/video_source_mux.sv
// N-way pixel source selector: per-source hold registers, frame-aligned switching,
// stale-source fallback to source 0 and a one-cycle registered output stage.
module video_source_mux
    import video_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DATA_W       = 8,
    parameter int STALE_FRAMES = 2,
    parameter int SEL_W        = $clog2(NUM_SRC)
) (
    input logic              clk,
    input logic              reset,
    video_source_mux_if.slave bus
);
    localparam int               PIX_W     = 3 * DATA_W;
    localparam logic [SEL_W:0]   NUM_SRC_L = NUM_SRC[SEL_W:0];

    logic [PIX_W-1:0]   hold_q [NUM_SRC];
    logic [NUM_SRC-1:0] seen_q, seen_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic [SEL_W-1:0]   act_sel_q, act_sel_d;
    logic [SEL_W-1:0]   eff_s, eff_d;
    logic               fb_s, fb_next_s;
    logic               switch_pulse_q, switch_pulse_d;
    logic [PIX_W-1:0]   pix_s;
    logic [DATA_W-1:0]  red_q, green_q, blue_q;
    logic [DATA_W-1:0]  red_d, green_d, blue_d;
    logic [2:0]         sync_q;

    stale_watchdog #(
        .STALE_FRAMES(STALE_FRAMES)
    ) u_watchdog (
        .clk           (clk),
        .reset         (reset),
        .seen_sel      (seen_q[act_sel_q]),
        .start_of_frame(bus.start_of_frame),
        .sel_changed   (pend_sel_q != act_sel_q),
        .fallback_en   (bus.fallback_en),
        .is_src0       (pend_sel_q == {SEL_W{1'b0}}),
        .in_fallback   (fb_s),
        .fallback_next (fb_next_s)
    );

    // Hold registers capture every source regardless of which one is selected
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) hold_q[i] <= {PIX_W{1'b0}};
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.src_valid[i]) hold_q[i] <= bus.src_rgb[i*PIX_W +: PIX_W];
            end
        end
    end

    // Selection, seen flags and the output pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_q         <= {NUM_SRC{1'b0}};
            pend_sel_q     <= {SEL_W{1'b0}};
            act_sel_q      <= {SEL_W{1'b0}};
            switch_pulse_q <= 1'b0;
            red_q          <= {DATA_W{1'b0}};
            green_q        <= {DATA_W{1'b0}};
            blue_q         <= {DATA_W{1'b0}};
            sync_q         <= 3'b000;
        end else begin
            seen_q         <= seen_d;
            pend_sel_q     <= pend_sel_d;
            act_sel_q      <= act_sel_d;
            switch_pulse_q <= switch_pulse_d;
            red_q          <= red_d;
            green_q        <= green_d;
            blue_q         <= blue_d;
            sync_q         <= {bus.vde, bus.hsync, bus.vsync};
        end
    end

    // Valid on the frame-boundary cycle already belongs to the new frame
    always_comb begin
        if ({1'b0, bus.sel_req} < NUM_SRC_L) begin
            pend_sel_d = bus.sel_req;
        end else begin
            pend_sel_d = pend_sel_q;
        end
        if (bus.start_of_frame) begin
            seen_d    = bus.src_valid;
            act_sel_d = pend_sel_q;
        end else begin
            seen_d    = seen_q | bus.src_valid;
            act_sel_d = act_sel_q;
        end
        eff_s          = fb_s ? {SEL_W{1'b0}} : act_sel_q;
        eff_d          = fb_next_s ? {SEL_W{1'b0}} : act_sel_d;
        switch_pulse_d = bus.start_of_frame && (eff_d != eff_s);
        pix_s          = hold_q[eff_s];
        if (bus.vde) begin
            red_d   = pix_s[PIX_W-1 -: DATA_W];
            green_d = pix_s[2*DATA_W-1 -: DATA_W];
            blue_d  = pix_s[DATA_W-1:0];
        end else begin
            red_d   = {DATA_W{1'b0}};
            green_d = {DATA_W{1'b0}};
            blue_d  = {DATA_W{1'b0}};
        end
    end

    assign bus.out_red      = red_q;
    assign bus.out_green    = green_q;
    assign bus.out_blue     = blue_q;
    assign bus.out_vde      = sync_q[2];
    assign bus.out_hsync    = sync_q[1];
    assign bus.out_vsync    = sync_q[0];
    assign bus.act_sel      = act_sel_q;
    assign bus.stale        = fb_s;
    assign bus.switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_video_source_mux.sv
// Directed bench for video_source_mux: frame-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_video_source_mux;
    import video_pkg::*;

    localparam int NS    = 4;
    localparam int STALE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    video_source_mux_if #(.NUM_SRC(NS), .DATA_W(8)) bus ();
    video_source_mux_if #(.NUM_SRC(3),  .DATA_W(8)) bus3 ();

    video_source_mux #(.NUM_SRC(NS), .DATA_W(8), .STALE_FRAMES(STALE)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    video_source_mux #(.NUM_SRC(3), .DATA_W(8), .STALE_FRAMES(STALE)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave));

    assign bus3.src_valid      = 3'b000;
    assign bus3.src_rgb        = 72'h0;
    assign bus3.fallback_en    = 1'b0;
    assign bus3.vde            = bus.vde;
    assign bus3.hsync          = bus.hsync;
    assign bus3.vsync          = bus.vsync;
    assign bus3.start_of_frame = bus.start_of_frame;

    always #5 clk = ~clk;

    // Reference model state (frame-level view of the selector)
    int   m_pend = 0, m_act = 0, m_miss = 0;
    bit   m_fb = 1'b0;
    bit   m_seen [NS];
    rgb_t m_hold [NS];
    rgb_t e_rgb = '0;
    bit   e_vde = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_pulse = 1'b0, e_stale = 1'b0;
    int   e_act = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  eff;
        int  nact;
        bit  was_seen;
        eff   = m_fb ? 0 : m_act;
        e_vde = bus.vde;
        e_hs  = bus.hsync;
        e_vs  = bus.vsync;
        e_rgb = bus.vde ? m_hold[eff] : '0;
        e_pulse = 1'b0;
        if (reset) begin
            m_pend = 0; m_act = 0; m_miss = 0; m_fb = 1'b0;
            for (int i = 0; i < NS; i++) begin m_seen[i] = 1'b0; m_hold[i] = '0; end
            e_vde = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_rgb = '0;
        end else begin
            if (bus.start_of_frame) begin
                was_seen = m_seen[m_act];
                nact     = m_pend;
                if (nact != m_act || was_seen || nact == 0) m_miss = 0;
                else if (m_miss < 15) m_miss = m_miss + 1;
                if (m_fb) m_fb = !(was_seen || !bus.fallback_en || nact == 0);
                else      m_fb = bus.fallback_en && nact != 0 && m_miss >= STALE;
                e_pulse = ((m_fb ? 0 : nact) != eff);
                m_act   = nact;
                for (int i = 0; i < NS; i++) m_seen[i] = bus.src_valid[i];
            end else begin
                for (int i = 0; i < NS; i++) m_seen[i] = m_seen[i] | bus.src_valid[i];
            end
            for (int i = 0; i < NS; i++)
                if (bus.src_valid[i]) m_hold[i] = rgb_t'(bus.src_rgb[i*24 +: 24]);
            if (int'(bus.sel_req) < NS) m_pend = int'(bus.sel_req);
        end
        e_act   = m_act;
        e_stale = m_fb;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin m_seen[i] = 1'b0; m_hold[i] = '0; end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("out_red",      bus.out_red,      e_rgb.r);
                check("out_green",    bus.out_green,    e_rgb.g);
                check("out_blue",     bus.out_blue,     e_rgb.b);
                check("out_vde",      bus.out_vde,      e_vde);
                check("out_hsync",    bus.out_hsync,    e_hs);
                check("out_vsync",    bus.out_vsync,    e_vs);
                check("act_sel",      bus.act_sel,      e_act);
                check("stale",        bus.stale,        e_stale);
                check("switch_pulse", bus.switch_pulse, e_pulse);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input int s, input rgb_t c);
        bus.src_valid    = '0;
        bus.src_valid[s] = 1'b1;
        bus.src_rgb[s*24 +: 24] = c;
        cyc(1);
        bus.src_valid    = '0;
    endtask

    task automatic sof_pulse();
        bus.start_of_frame = 1'b1;
        cyc(1);
        bus.start_of_frame = 1'b0;
    endtask

    initial begin
        bus.src_valid = '0; bus.src_rgb = '0; bus.sel_req = '0; bus.fallback_en = 1'b0;
        bus.vde = 1'b0; bus.hsync = 1'b0; bus.vsync = 1'b0; bus.start_of_frame = 1'b0;
        bus3.sel_req = 2'd2;
        cyc(2);
        chk_en = 1'b1;
        cyc(1);
        check("rst_act_sel", bus.act_sel, 32'd0);
        check("rst_out_red", bus.out_red, 32'd0);
        check("rst_stale",   bus.stale,   32'd0);
        reset = 1'b0;

        // Basic select of source 2
        pix(0, 24'h0A0B0C);
        bus.sel_req = 2'd2;
        pix(2, 24'h112233);
        sof_pulse();
        check("sel2_pulse", bus.switch_pulse, 32'd1);
        check("sel2_act",   bus.act_sel,      32'd2);
        check("n3_act",     bus3.act_sel,     32'd2);
        check("n3_pulse",   bus3.switch_pulse, 32'd1);
        bus.vde = 1'b1; bus.hsync = 1'b1;
        cyc(1);
        check("sel2_red",   bus.out_red,   32'h11);
        check("sel2_green", bus.out_green, 32'h22);
        check("sel2_blue",  bus.out_blue,  32'h33);
        check("sel2_vde",   bus.out_vde,   32'd1);
        check("sel2_nopulse", bus.switch_pulse, 32'd0);
        bus.vde = 1'b0; bus.hsync = 1'b0;
        cyc(1);
        check("vde_lag_off", bus.out_vde, 32'd0);

        // Mid-frame request 2 -> 3 waits for the frame boundary
        pix(3, 24'h445566);
        bus.sel_req = 2'd3;
        bus3.sel_req = 2'd3;
        pix(2, 24'h112233);
        bus.vde = 1'b1; bus.vsync = 1'b1;
        cyc(1);
        check("mid_red_hold", bus.out_red, 32'h11);
        check("mid_act_hold", bus.act_sel, 32'd2);
        bus.vde = 1'b0; bus.vsync = 1'b0;
        sof_pulse();
        check("sel3_pulse",  bus.switch_pulse, 32'd1);
        check("sel3_act",    bus.act_sel,      32'd3);
        check("n3_oor_act",  bus3.act_sel,     32'd2);
        check("n3_oor_pulse", bus3.switch_pulse, 32'd0);
        cyc(1);
        check("sel3_pulse_end", bus.switch_pulse, 32'd0);
        bus.vde = 1'b1;
        cyc(1);
        check("sel3_red", bus.out_red, 32'h44);
        bus.vde = 1'b0;

        // Stale fallback on a silent source 1
        bus.sel_req = 2'd1; bus.fallback_en = 1'b1;
        cyc(1);
        sof_pulse();
        cyc(3);
        sof_pulse();
        check("stale_after1", bus.stale, 32'd0);
        cyc(3);
        sof_pulse();
        check("stale_after2", bus.stale, 32'd1);
        check("stale_pulse",  bus.switch_pulse, 32'd1);
        bus.vde = 1'b1;
        cyc(1);
        check("fb_red", bus.out_red, 32'h0A);
        check("fb_blue", bus.out_blue, 32'h0C);
        bus.vde = 1'b0;
        pix(1, 24'h778899);
        cyc(1);
        sof_pulse();
        check("recover_stale", bus.stale, 32'd0);
        check("recover_pulse", bus.switch_pulse, 32'd1);
        bus.vde = 1'b1;
        cyc(1);
        check("recover_red", bus.out_red, 32'h77);
        bus.vde = 1'b0;

        // Watchdog disabled: a silent source never goes stale
        bus.fallback_en = 1'b0;
        for (int f = 0; f < 17; f++) begin
            cyc(2);
            sof_pulse();
        end
        check("nofb_stale", bus.stale,   32'd0);
        check("nofb_act",   bus.act_sel, 32'd1);
        bus.vde = 1'b1;
        cyc(1);
        check("nofb_green", bus.out_green, 32'h88);

        // Reset in the middle of active video
        bus.hsync = 1'b1;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        check("mrst_red",   bus.out_red,   32'd0);
        check("mrst_vde",   bus.out_vde,   32'd0);
        check("mrst_hsync", bus.out_hsync, 32'd0);
        check("mrst_act",   bus.act_sel,   32'd0);
        reset = 1'b0; bus.vde = 1'b0; bus.hsync = 1'b0;
        pix(0, 24'hC1C2C3);
        bus.vde = 1'b1;
        cyc(1);
        check("post_rst_red",  bus.out_red,  32'hC1);
        check("post_rst_blue", bus.out_blue, 32'hC3);
        bus.vde = 1'b0;
        sof_pulse();
        check("post_rst_sof_act", bus.act_sel, 32'd1);
        check("n3_stale", bus3.stale, 32'd0);
        cyc(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
